// File: rtl/spmv_fill_pkg.sv
// Shared sizing helpers, default widths and types for the slow-block fill arbiter.
`ifndef NUM_SEG_PER_STG
`define NUM_SEG_PER_STG 4
`endif
`ifndef BITS_INPUT_ADDR_SLOW_BLK
`define BITS_INPUT_ADDR_SLOW_BLK 4
`endif
`ifndef BLK_SLOW_PARR_WR_NUM
`define BLK_SLOW_PARR_WR_NUM 2
`endif
`ifndef DATA_WIDTH_INPUT
`define DATA_WIDTH_INPUT 8
`endif

package spmv_fill_pkg;

  function automatic int unsigned bidx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned NUM_SLOW_BLK_DEF = `NUM_SEG_PER_STG;
  localparam int unsigned ADDR_W_DEF       = `BITS_INPUT_ADDR_SLOW_BLK;
  localparam int unsigned WR_NUM_DEF       = `BLK_SLOW_PARR_WR_NUM;
  localparam int unsigned DIN_W_DEF        = `DATA_WIDTH_INPUT;
  localparam int unsigned MAX_OUTST_DEF    = 4;
  localparam int unsigned BIDX_W_DEF       = bidx_w(NUM_SLOW_BLK_DEF);

  // Tag layout for the default configuration.
  typedef struct packed {
    logic [BIDX_W_DEF-1:0] idx;
    logic [ADDR_W_DEF-1:0] addr;
  } fill_tag_t;

  typedef enum logic {StIdle, StHold} arb_state_e;

endpackage

// File: rtl/slow_blk_fill_if.sv
// Request, memory and bin-write signals between the fill arbiter and its environment.
interface slow_blk_fill_if import spmv_fill_pkg::*; #(
  parameter int unsigned NUM_SLOW_BLK = NUM_SLOW_BLK_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned WR_NUM       = WR_NUM_DEF,
  parameter int unsigned DIN_W        = DIN_W_DEF,
  parameter int unsigned MAX_OUTST    = MAX_OUTST_DEF
) ();
  localparam int unsigned BIDX_W = bidx_w(NUM_SLOW_BLK);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST) + 1;

  logic                                         unit_en;
  logic [NUM_SLOW_BLK-1:0]                      send_fill_req_blk_slow;
  logic [NUM_SLOW_BLK-1:0][ADDR_W-1:0]          bin_to_fill_addr_blk_slow;
  logic [NUM_SLOW_BLK-1:0]                      fill_req_accepted_blk_slow;
  logic                                         mem_req_valid;
  logic                                         mem_req_ready;
  logic [BIDX_W+ADDR_W-1:0]                     mem_req_addr;
  logic                                         mem_rsp_valid;
  logic [WR_NUM-1:0][DIN_W-1:0]                 mem_rsp_data;
  logic [NUM_SLOW_BLK-1:0]                      wr_en_unit_input;
  logic [NUM_SLOW_BLK-1:0][ADDR_W-1:0]          wr_addr_unit_input;
  logic [NUM_SLOW_BLK-1:0][WR_NUM-1:0][DIN_W-1:0] data_in_unit;
  logic [CNT_W-1:0]                             outst_cnt;
  logic                                         rsp_err;

  modport master (
    input  unit_en, send_fill_req_blk_slow, bin_to_fill_addr_blk_slow, mem_req_ready,
           mem_rsp_valid, mem_rsp_data,
    output fill_req_accepted_blk_slow, mem_req_valid, mem_req_addr, wr_en_unit_input,
           wr_addr_unit_input, data_in_unit, outst_cnt, rsp_err
  );

  modport slave (
    output unit_en, send_fill_req_blk_slow, bin_to_fill_addr_blk_slow, mem_req_ready,
           mem_rsp_valid, mem_rsp_data,
    input  fill_req_accepted_blk_slow, mem_req_valid, mem_req_addr, wr_en_unit_input,
           wr_addr_unit_input, data_in_unit, outst_cnt, rsp_err
  );
endinterface

// File: rtl/fill_tag_fifo.sv
// In-order tag FIFO holding {block, bin} for each fill in flight.
module fill_tag_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = $clog2(Depth) + 1
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             push,
  input  logic [Width-1:0] din,
  input  logic             pop,
  output logic [Width-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == CntW'(Depth));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage needs no reset: empty/count gate every read.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CntW'(do_push) - CntW'(do_pop);
    end
  end
endmodule

// File: rtl/slow_blk_fill_arbiter.sv
// Round-robin arbiter for slow-block bin fills: issues memory reads and steers the
// in-order responses back into the granted block's input bin.
module slow_blk_fill_arbiter import spmv_fill_pkg::*; #(
  parameter int unsigned NUM_SLOW_BLK = NUM_SLOW_BLK_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned WR_NUM       = WR_NUM_DEF,
  parameter int unsigned DIN_W        = DIN_W_DEF,
  parameter int unsigned MAX_OUTST    = MAX_OUTST_DEF
) (
  input logic             clk,
  input logic             rst_b,
  slow_blk_fill_if.master bus
);
  localparam int unsigned BIDX_W = bidx_w(NUM_SLOW_BLK);
  localparam int unsigned CNT_W  = $clog2(MAX_OUTST) + 1;

  typedef struct packed {
    logic [BIDX_W-1:0] idx;
    logic [ADDR_W-1:0] addr;
  } tag_t;

  arb_state_e                   state_q;
  logic [BIDX_W-1:0]            req_idx_q, rr_ptr_q, win_idx, rr_next;
  logic [ADDR_W-1:0]            req_addr_q, wr_addr_q;
  logic [NUM_SLOW_BLK-1:0]      pend_q, pend_d, elig, accept, wr_en_q, wr_en_d;
  logic [WR_NUM-1:0][DIN_W-1:0] wr_data_q;
  logic                         win_found, handshake, grant, pop, fifo_full, fifo_empty;
  logic                         rsp_err_q;
  logic [CNT_W-1:0]             cnt;
  tag_t                         push_tag, head_tag;
  int unsigned                  cand;

  assign elig      = bus.send_fill_req_blk_slow & ~pend_q;
  assign handshake = (state_q == StHold) & bus.mem_req_ready;
  assign pop       = bus.mem_rsp_valid & ~fifo_empty;
  assign grant     = (state_q == StIdle) & bus.unit_en & win_found & ~fifo_full;
  assign rr_next   = (req_idx_q == BIDX_W'(NUM_SLOW_BLK - 1)) ? '0 : req_idx_q + 1'b1;
  assign push_tag  = '{idx: req_idx_q, addr: req_addr_q};

  // First eligible block at or after rr_ptr, wrapping.
  always_comb begin
    win_idx   = '0;
    win_found = 1'b0;
    cand      = 0;
    for (int unsigned off = 0; off < NUM_SLOW_BLK; off++) begin
      cand = 32'(rr_ptr_q) + off;
      if (cand >= NUM_SLOW_BLK) cand = cand - NUM_SLOW_BLK;
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = BIDX_W'(cand);
      end
    end
  end

  always_comb begin
    pend_d  = pend_q;
    accept  = '0;
    wr_en_d = '0;
    if (pop) begin
      pend_d[head_tag.idx]  = 1'b0;
      wr_en_d[head_tag.idx] = 1'b1;
    end
    if (handshake) begin
      pend_d[req_idx_q] = 1'b1;
      accept[req_idx_q] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_q    <= StIdle;
      req_idx_q  <= '0;
      req_addr_q <= '0;
      rr_ptr_q   <= '0;
      pend_q     <= '0;
    end else begin
      pend_q <= pend_d;
      unique case (state_q)
        StIdle: begin
          if (grant) begin
            state_q    <= StHold;
            req_idx_q  <= win_idx;
            req_addr_q <= bus.bin_to_fill_addr_blk_slow[win_idx];
          end
        end
        StHold: begin
          if (bus.mem_req_ready) begin
            state_q  <= StIdle;
            rr_ptr_q <= rr_next;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      wr_en_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      wr_en_q <= wr_en_d;
      if (pop) begin
        wr_addr_q <= head_tag.addr;
        wr_data_q <= bus.mem_rsp_data;
      end
      if (bus.mem_rsp_valid && fifo_empty) rsp_err_q <= 1'b1;
    end
  end

  fill_tag_fifo #(
    .Depth (MAX_OUTST),
    .Width ($bits(tag_t)),
    .CntW  (CNT_W)
  ) u_tag_fifo (
    .clk   (clk),
    .rst_b (rst_b),
    .push  (handshake),
    .din   (push_tag),
    .pop   (pop),
    .dout  (head_tag),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (cnt)
  );

  assign bus.mem_req_valid              = (state_q == StHold);
  assign bus.mem_req_addr               = {req_idx_q, req_addr_q};
  assign bus.fill_req_accepted_blk_slow = accept;
  assign bus.wr_en_unit_input           = wr_en_q;
  assign bus.wr_addr_unit_input         = {NUM_SLOW_BLK{wr_addr_q}};
  assign bus.data_in_unit               = {NUM_SLOW_BLK{wr_data_q}};
  assign bus.outst_cnt                  = cnt;
  assign bus.rsp_err                    = rsp_err_q;
endmodule

// File: tb/tb_slow_blk_fill_arbiter.sv
// Bench for slow_blk_fill_arbiter: vector table, directed corner sequences, random vs model.
module tb_slow_blk_fill_arbiter;
  import spmv_fill_pkg::*;

  localparam int unsigned N = 4, AW = 4, WN = 2, DW = 8, MO = 4;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  always #5 clk = ~clk;

  slow_blk_fill_if #(.NUM_SLOW_BLK(N), .ADDR_W(AW), .WR_NUM(WN), .DIN_W(DW), .MAX_OUTST(MO)) bus ();

  slow_blk_fill_arbiter #(
    .NUM_SLOW_BLK (N),
    .ADDR_W       (AW),
    .WR_NUM       (WN),
    .DIN_W        (DW),
    .MAX_OUTST    (MO)
  ) dut (
    .clk   (clk),
    .rst_b (rst_b),
    .bus   (bus)
  );

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    bus.unit_en = 1'b0;
    bus.send_fill_req_blk_slow = '0;
    bus.bin_to_fill_addr_blk_slow = '0;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data = '0;
    rst_b = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_b = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic en; logic [3:0] req; logic [3:0] a2; logic rdy; logic rv; logic [15:0] rd;
    logic vld; logic [5:0] maddr; logic [3:0] acc; logic [3:0] wren; logic [3:0] waddr;
    logic [15:0] wdata; logic [2:0] cnt; logic err;
  } vec_t;
  vec_t vt[10];

  // Random-phase reference model state.
  logic       m_busy, m_err;
  int         m_idx, m_rr, g;
  logic [3:0] m_addr, m_wren, m_waddr;
  logic [15:0] m_wdata;
  logic [N-1:0] m_pend;
  fill_tag_t  m_q[$];
  fill_tag_t  t;
  logic       r_en, r_rdy, r_rv;
  logic [3:0] r_req;
  logic [N-1:0][AW-1:0] r_addr;
  logic [15:0] r_data;
  logic [3:0] acc_log[$];
  logic       got;

  initial begin
    //          en    req      a2    rdy   rv    rd        vld   maddr  acc      wren     waddr wdata    cnt   err
    vt[0] = '{1'b1, 4'b0100, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b0};
    vt[1] = '{1'b1, 4'b0100, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b1, 6'h25, 4'b0100, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b0};
    vt[2] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd1, 1'b0};
    vt[3] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd1, 1'b0};
    vt[4] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b1, 16'hA5C3, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd1, 1'b0};
    vt[5] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0100, 4'd5, 16'hA5C3, 3'd0, 1'b0};
    vt[6] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b0};
    vt[7] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b1, 16'h1234, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b0};
    vt[8] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b1};
    vt[9] = '{1'b1, 4'b0000, 4'd5, 1'b1, 1'b0, 16'h0000, 1'b0, 6'h00, 4'b0000, 4'b0000, 4'd0, 16'h0000, 3'd0, 1'b1};

    #1;
    do_reset();
    @(negedge clk);
    chk("reset_outs", 64'({bus.mem_req_valid, bus.fill_req_accepted_blk_slow, bus.wr_en_unit_input,
                           bus.outst_cnt, bus.rsp_err, bus.mem_req_addr}), 64'(0));
    chk("reset_data", 64'({bus.wr_addr_unit_input, bus.data_in_unit}), 64'(0));
    next_cycle();

    // Single request from block 2, response, then a spurious response.
    for (int i = 0; i < 10; i++) begin
      bus.unit_en = vt[i].en;
      bus.send_fill_req_blk_slow = vt[i].req;
      bus.bin_to_fill_addr_blk_slow = '0;
      bus.bin_to_fill_addr_blk_slow[2] = vt[i].a2;
      bus.mem_req_ready = vt[i].rdy;
      bus.mem_rsp_valid = vt[i].rv;
      bus.mem_rsp_data = vt[i].rd;
      @(negedge clk);
      chk("tbl_valid", 64'(bus.mem_req_valid), 64'(vt[i].vld));
      if (vt[i].vld) chk("tbl_maddr", 64'(bus.mem_req_addr), 64'(vt[i].maddr));
      chk("tbl_accept", 64'(bus.fill_req_accepted_blk_slow), 64'(vt[i].acc));
      chk("tbl_wren", 64'(bus.wr_en_unit_input), 64'(vt[i].wren));
      for (int l = 0; l < N; l++) begin
        if (vt[i].wren[l]) begin
          chk("tbl_waddr", 64'(bus.wr_addr_unit_input[l]), 64'(vt[i].waddr));
          chk("tbl_wdata", 64'(bus.data_in_unit[l]), 64'(vt[i].wdata));
        end
      end
      chk("tbl_cnt", 64'(bus.outst_cnt), 64'(vt[i].cnt));
      chk("tbl_err", 64'(bus.rsp_err), 64'(vt[i].err));
      next_cycle();
    end

    // Ready held low for six cycles while a request is parked.
    do_reset();
    bus.unit_en = 1'b1;
    bus.send_fill_req_blk_slow = 4'b0001;
    bus.bin_to_fill_addr_blk_slow[0] = 4'd3;
    @(negedge clk);
    chk("hold_pre_valid", 64'(bus.mem_req_valid), 64'(0));
    next_cycle();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("hold_stable", 64'({bus.mem_req_valid, bus.mem_req_addr, bus.fill_req_accepted_blk_slow}),
          64'({1'b1, 6'h03, 4'b0000}));
      next_cycle();
    end
    bus.mem_req_ready = 1'b1;
    bus.send_fill_req_blk_slow = '0;
    @(negedge clk);
    chk("hold_accept", 64'(bus.fill_req_accepted_blk_slow), 64'(4'b0001));
    next_cycle();
    bus.mem_req_ready = 1'b0;
    @(negedge clk);
    chk("hold_after", 64'({bus.mem_req_valid, bus.fill_req_accepted_blk_slow, bus.outst_cnt}),
        64'({1'b0, 4'b0000, 3'd1}));

    // All blocks requesting: round-robin order, fill of the tag FIFO, regrant.
    do_reset();
    bus.unit_en = 1'b1;
    bus.send_fill_req_blk_slow = 4'b1111;
    bus.bin_to_fill_addr_blk_slow = {4'hD, 4'hC, 4'hB, 4'hA};
    bus.mem_req_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.fill_req_accepted_blk_slow != 4'b0000) acc_log.push_back(bus.fill_req_accepted_blk_slow);
      next_cycle();
    end
    chk("rr_grant_count", 64'(acc_log.size()), 64'(4));
    for (int k = 0; k < 4 && k < acc_log.size(); k++)
      chk("rr_grant_order", 64'(acc_log[k]), 64'(4'b0001 << k));
    @(negedge clk);
    chk("full_cnt", 64'(bus.outst_cnt), 64'(4));
    chk("full_no_valid", 64'(bus.mem_req_valid), 64'(0));
    next_cycle();
    bus.mem_rsp_valid = 1'b1;
    bus.mem_rsp_data = 16'h0F0F;
    @(negedge clk);
    chk("rsp_no_early_wr", 64'(bus.wr_en_unit_input), 64'(0));
    next_cycle();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("rsp_wr_blk0", 64'({bus.wr_en_unit_input, bus.outst_cnt, bus.data_in_unit[0]}),
        64'({4'b0001, 3'd3, 16'h0F0F}));
    got = 1'b0;
    for (int w = 0; w < 2 && !got; w++) begin
      next_cycle();
      @(negedge clk);
      got = bus.mem_req_valid;
    end
    chk("regrant_valid", 64'(got), 64'(1));
    chk("regrant_addr", 64'(bus.mem_req_addr), 64'({2'd0, 4'hA}));
    chk("regrant_accept", 64'(bus.fill_req_accepted_blk_slow), 64'(4'b0001));

    // Reset with three fills outstanding and a request parked.
    next_cycle();
    bus.send_fill_req_blk_slow = 4'b0010;
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b1;
    next_cycle();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("pop_blk1", 64'({bus.wr_en_unit_input, bus.outst_cnt}), 64'({4'b0010, 3'd3}));
    next_cycle();
    @(negedge clk);
    chk("park_blk1", 64'({bus.mem_req_valid, bus.mem_req_addr}), 64'({1'b1, 2'd1, 4'hB}));
    #1 rst_b = 1'b1;
    #1;
    chk("async_rst", 64'({bus.mem_req_valid, bus.mem_req_addr, bus.fill_req_accepted_blk_slow,
                          bus.wr_en_unit_input, bus.outst_cnt, bus.rsp_err}), 64'(0));
    next_cycle();
    rst_b = 1'b0;
    bus.send_fill_req_blk_slow = '0;
    bus.mem_rsp_valid = 1'b1;
    next_cycle();
    bus.mem_rsp_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_err", 64'({bus.rsp_err, bus.wr_en_unit_input, bus.outst_cnt}),
        64'({1'b1, 4'b0000, 3'd0}));

    // Random traffic against a transaction-level model.
    do_reset();
    m_busy = 1'b0; m_err = 1'b0; m_idx = 0; m_rr = 0; m_addr = '0;
    m_wren = '0; m_waddr = '0; m_wdata = '0; m_pend = '0;
    m_q.delete();
    for (int c = 0; c < 600; c++) begin
      r_en   = ($urandom_range(4) != 0);
      r_req  = 4'($urandom());
      r_addr = 16'($urandom());
      r_rdy  = 1'($urandom());
      r_rv   = ($urandom_range(3) == 0);
      r_data = 16'($urandom());
      bus.unit_en = r_en;
      bus.send_fill_req_blk_slow = r_req;
      bus.bin_to_fill_addr_blk_slow = r_addr;
      bus.mem_req_ready = r_rdy;
      bus.mem_rsp_valid = r_rv;
      bus.mem_rsp_data = r_data;
      @(negedge clk);
      chk("rnd_outs", 64'({bus.mem_req_valid, bus.fill_req_accepted_blk_slow, bus.wr_en_unit_input,
                           bus.outst_cnt, bus.rsp_err}),
          64'({m_busy, (m_busy && r_rdy) ? 4'(4'b0001 << m_idx) : 4'b0000, m_wren,
               3'(m_q.size()), m_err}));
      if (m_busy) chk("rnd_maddr", 64'(bus.mem_req_addr), 64'({2'(m_idx), m_addr}));
      for (int l = 0; l < N; l++) begin
        if (m_wren[l]) begin
          chk("rnd_waddr", 64'(bus.wr_addr_unit_input[l]), 64'(m_waddr));
          chk("rnd_wdata", 64'(bus.data_in_unit[l]), 64'(m_wdata));
        end
      end
      // Advance the model by one clock using this cycle's inputs.
      g = -1;
      if (!m_busy && r_en && m_q.size() < MO)
        for (int k = 0; k < N; k++)
          if (g < 0 && r_req[(m_rr + k) % N] && !m_pend[(m_rr + k) % N]) g = (m_rr + k) % N;
      if (r_rv && m_q.size() > 0) begin
        t = m_q.pop_front();
        m_wren = 4'(4'b0001 << t.idx);
        m_waddr = t.addr;
        m_wdata = r_data;
        m_pend[t.idx] = 1'b0;
      end else begin
        m_wren = '0;
        if (r_rv) m_err = 1'b1;
      end
      if (m_busy && r_rdy) begin
        t.idx = 2'(m_idx);
        t.addr = m_addr;
        m_q.push_back(t);
        m_pend[m_idx] = 1'b1;
        m_rr = (m_idx + 1) % N;
        m_busy = 1'b0;
      end else if (g >= 0) begin
        m_busy = 1'b1;
        m_idx = g;
        m_addr = r_addr[g];
      end
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
